// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter for the single-wire link.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional even parity, stop(1).
// Each bit is held for CLKS_PER_BIT clocks; TX_OUT is registered and idles high.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN inserts the parity bit.
module serial_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  output logic                  READY,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic                  r_par;
`endif

  logic                  w_last_clk;
  logic                  w_last_bit;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // End-of-bit-period and last-data-bit decodes, plus the next shift value
  assign w_last_clk  = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last_bit  = (r_bit == BW'(DATA_WIDTH - 1));
  assign w_shift_nxt = r_shift >> 1;

  assign READY  = ~r_busy;
  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

  // Frame sequencer: TX_OUT is loaded one edge ahead so the line changes
  // in the cycle right after each state transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (DATA_VALID) begin
            r_shift <= DATA_IN;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_par   <= ^DATA_IN;
`endif
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_last_clk) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_last_clk) begin
            r_cnt   <= '0;
            r_shift <= w_shift_nxt;
            if (w_last_bit) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= w_shift_nxt[0];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY: begin
          if (w_last_clk) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_last_clk) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: unit A (8 bits, 4 clks/bit), unit B (4 bits, 1 clk/bit).
// Expected line levels come from a per-frame bit list built from the frame rules.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_din;
  logic       a_vld;
  logic       a_rdy, a_tx, a_busy, a_done;
  logic [3:0] b_din;
  logic       b_vld;
  logic       b_rdy, b_tx, b_busy, b_done;

  int checks = 0;
  int errors = 0;

  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_a (
    .CLK(clk), .RST(rst), .DATA_IN(a_din), .DATA_VALID(a_vld),
    .READY(a_rdy), .TX_OUT(a_tx), .BUSY(a_busy), .DONE(a_done)
  );

  serial_frame_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) u_b (
    .CLK(clk), .RST(rst), .DATA_IN(b_din), .DATA_VALID(b_vld),
    .READY(b_rdy), .TX_OUT(b_tx), .BUSY(b_busy), .DONE(b_done)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [15:0] d);
    if (sel) begin
      b_vld = v;
      b_din = d[3:0];
    end else begin
      a_vld = v;
      a_din = d[7:0];
    end
  endtask

  task automatic chk_out(input bit sel, input string tag, input logic tx,
                         input logic busy, input logic done);
    if (sel) begin
      chk({tag, ".B.tx"},    b_tx,   tx);
      chk({tag, ".B.busy"},  b_busy, busy);
      chk({tag, ".B.ready"}, b_rdy,  ~busy);
      chk({tag, ".B.done"},  b_done, done);
    end else begin
      chk({tag, ".A.tx"},    a_tx,   tx);
      chk({tag, ".A.busy"},  a_busy, busy);
      chk({tag, ".A.ready"}, a_rdy,  ~busy);
      chk({tag, ".A.done"},  a_done, done);
    end
  endtask

  // noise: 0 = inputs quiet while busy, 1 = random valid pulses and data,
  // 2 = valid held high with changing data. abort_k >= 0 asserts reset at that cycle.
  task automatic frame(input bit sel, input logic [15:0] d, input int noise,
                       input int abort_k);
    logic bits[$];
    logic p;
    int   w;
    int   cpb;
    int   nf;
    logic [15:0] r;
    w   = sel ? 4 : 8;
    cpb = sel ? 1 : 4;
    p   = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (P == 1) bits.push_back(p);
    bits.push_back(1'b1);
    nf = bits.size() * cpb;

    set_in(sel, 1'b1, d);
    chk(sel ? "pre.B.ready" : "pre.A.ready", sel ? b_rdy : a_rdy, 1'b1);
    tick;
    if (noise == 0) set_in(sel, 1'b0, 16'h0);

    for (int k = 0; k < nf; k++) begin
      if (k == abort_k) begin
        rst = 1'b1;
        set_in(sel, 1'b0, 16'h0);
        tick;
        chk_out(sel, "abort1", 1'b1, 1'b0, 1'b0);
        tick;
        chk_out(sel, "abort2", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < nf + 2; j++) begin
          tick;
          chk_out(sel, "post_abort", 1'b1, 1'b0, 1'b0);
        end
        return;
      end
      chk_out(sel, "frame", bits[k / cpb], 1'b1, 1'b0);
      r = 16'($urandom);
      if (noise == 1) set_in(sel, 1'($urandom_range(0, 1)), r);
      else if (noise == 2) set_in(sel, 1'b1, r);
      tick;
    end
    chk_out(sel, "done", 1'b1, 1'b0, 1'b1);
    set_in(sel, 1'b0, 16'h0);
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      chk_out(sel, "idle", 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] d;
    bit          s;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 16'h0);
    set_in(1'b1, 1'b0, 16'h0);
    tick;
    tick;
    chk_out(1'b0, "reset", 1'b1, 1'b0, 1'b0);
    chk_out(1'b1, "reset", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1'b0, 2);

    // Single frame 0xA5
    frame(1'b0, 16'h00A5, 0, -1);
    idle(1'b0, 3);

    // Reset mid-traffic (inside the start bit / early data)
    d = 16'($urandom);
    frame(1'b0, d, 0, 7);

    // Back to back with valid held high; changing data while busy is ignored
    frame(1'b0, 16'h003C, 2, -1);
    frame(1'b0, 16'h00FF, 2, -1);
    idle(1'b0, 2);

    // Abort during data bit 3 (cycles 16..19 after accept), then 0x01
    frame(1'b0, 16'h005A, 0, 17);
    frame(1'b0, 16'h0001, 0, -1);
    idle(1'b0, 1);

    // One clock per bit, 4-bit word 0x7
    frame(1'b1, 16'h0007, 0, -1);
    frame(1'b1, 16'h000A, 2, -1);
    idle(1'b1, 2);

    // Valid pulses while busy produce no extra frame
    d = 16'($urandom);
    frame(1'b0, d, 1, -1);
    idle(1'b0, 3);

    // Randomized frames on both units, some back to back, some aborted
    for (int n = 0; n < 16; n++) begin
      s = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if ($urandom_range(0, 5) == 0)
        frame(s, d, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
      else
        frame(s, d, int'($urandom_range(0, 2)), -1);
      if ($urandom_range(0, 1) == 1) idle(s, int'($urandom_range(1, 3)));
    end
    idle(1'b0, 2);
    idle(1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
